// File: rtl/tick_sched.sv
// Programmable tick scheduler: divides clki by a configurable divisor,
// emitting a tick pulse, a square wave and a tick counter, with run/pause/idle control.
module tick_sched #(
    parameter int DIV_W   = 27,
    parameter int DEF_DIV = 25000000,
    parameter int SEC_W   = 16
) (
    input  logic             clki,
    input  logic             rst_n,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    output logic             tick,
    output logic             clk_out,
    output logic [SEC_W-1:0] sec_cnt,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    localparam logic [DIV_W-1:0] DEF_DIV_C = DIV_W'(DEF_DIV);
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [SEC_W-1:0]   sec_q, sec_d;
    logic               tick_q, tick_d;
    logic               clk_out_q, clk_out_d;

    assign cfg_ready = (state_q == S_IDLE);
    assign tick      = tick_q;
    assign clk_out   = clk_out_q;
    assign sec_cnt   = sec_q;
    assign state     = state_q;

    // State and datapath registers, cleared asynchronously on reset
    always_ff @(posedge clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= DEF_DIV_C;
            cnt_q     <= '0;
            sec_q     <= '0;
            tick_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            sec_q     <= sec_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
        end
    end

    // Next-state logic: divisor load, period counting and run control
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        sec_d     = sec_q;
        tick_d    = 1'b0;
        clk_out_d = clk_out_q;

        if (cfg_valid && cfg_ready) begin
            div_d = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    sec_d   = '0;
                end
            end
            S_RUN: begin
                // The stop edge still counts, so a due tick is not lost
                if (cnt_q == div_q - DIV_W'(1)) begin
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    clk_out_d = ~clk_out_q;
                    sec_d     = sec_q + SEC_W'(1);
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
                if (stop) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d   = S_IDLE;
                    cnt_d     = '0;
                    sec_d     = '0;
                    clk_out_d = 1'b0;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d   = S_IDLE;
                cnt_d     = '0;
                sec_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_tick_sched.sv
// Randomized and directed bench for tick_sched, checked against
// an arithmetic model built on the number of counted RUN edges.
module tb_tick_sched;

    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 6;
    localparam int SEC_W   = 4;

    logic             clki;
    logic             rst_n;
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             start;
    logic             stop;
    logic             tick;
    logic             clk_out;
    logic [SEC_W-1:0] sec_cnt;
    logic [1:0]       state;

    int n_err;
    int n_chk;

    // Model: m_total counts RUN edges since leaving IDLE
    int m_state;
    int m_div;
    int m_total;
    int m_tick;

    tick_sched #(
        .DIV_W  (DIV_W),
        .DEF_DIV(DEF_DIV),
        .SEC_W  (SEC_W)
    ) dut (
        .clki     (clki),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_div  (cfg_div),
        .cfg_ready(cfg_ready),
        .start    (start),
        .stop     (stop),
        .tick     (tick),
        .clk_out  (clk_out),
        .sec_cnt  (sec_cnt),
        .state    (state)
    );

    initial clki = 1'b0;
    always #5 clki = ~clki;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_div   = DEF_DIV;
        m_total = 0;
        m_tick  = 0;
    endtask

    task automatic model_edge();
        m_tick = 0;
        case (m_state)
            0: begin
                if (cfg_valid)
                    m_div = (int'(cfg_div) < 2) ? 2 : int'(cfg_div);
                if (start && !stop) begin
                    m_state = 1;
                    m_total = 0;
                end
            end
            1: begin
                m_total++;
                m_tick = (m_total % m_div == 0) ? 1 : 0;
                if (stop) m_state = 2;
            end
            default: begin
                if (stop) begin
                    m_state = 0;
                    m_total = 0;
                end else if (start) begin
                    m_state = 1;
                end
            end
        endcase
    endtask

    task automatic compare();
        chk("state", int'(state), m_state);
        chk("tick", int'(tick), m_tick);
        chk("sec_cnt", int'(sec_cnt), (m_total / m_div) % (1 << SEC_W));
        chk("clk_out", int'(clk_out), (m_total / m_div) % 2);
        chk("cfg_ready", int'(cfg_ready), (m_state == 0) ? 1 : 0);
    endtask

    task automatic step();
        @(posedge clki);
        model_edge();
        #1;
        compare();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic go_idle();
        start = 1'b0;
        stop  = 1'b1;
        steps(2);
        stop  = 1'b0;
    endtask

    task automatic launch(input int div, input bit load);
        cfg_valid = load;
        cfg_div   = DIV_W'(div);
        start     = 1'b1;
        stop      = 1'b0;
        step();
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    // Called just after an edge; pulses reset between edges
    task automatic async_rst();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        #2 rst_n = 1'b1;
    endtask

    initial begin
        n_err     = 0;
        n_chk     = 0;
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        start     = 1'b0;
        stop      = 1'b0;
        model_reset();
        #12;
        compare();
        rst_n = 1'b1;
        steps(3);

        // Load 4 together with start
        launch(4, 1'b1);
        steps(12);
        chk("load_sec", int'(sec_cnt), 3);
        chk("load_tick", int'(tick), 1);
        chk("load_clk", int'(clk_out), 1);
        go_idle();

        // Divisor 0 clamps to 2
        launch(0, 1'b1);
        steps(8);
        chk("clamp_sec", int'(sec_cnt), 4);
        go_idle();

        // Pause after 3 counted edges, resume 10 cycles later
        launch(5, 1'b1);
        steps(2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("pause_state", int'(state), 2);
        steps(10);
        chk("pause_sec", int'(sec_cnt), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("resume_tick0", int'(tick), 0);
        step();
        chk("resume_tick1", int'(tick), 1);

        // Divisor offered while running is ignored
        cfg_valid = 1'b1;
        cfg_div   = 8'd7;
        step();
        chk("blk_ready", int'(cfg_ready), 0);
        steps(12);
        cfg_valid = 1'b0;

        // start and stop together in RUN pause
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("prio_state", int'(state), 2);
        go_idle();

        // 17 ticks wrap a 4-bit counter to 1
        launch(3, 1'b1);
        steps(51);
        chk("wrap_sec", int'(sec_cnt), 1);

        // Async reset mid-RUN, then divisor back to default
        steps(2);
        async_rst();
        chk("rst_state", int'(state), 0);
        launch(0, 1'b0);
        steps(2 * DEF_DIV);
        chk("rst_div_sec", int'(sec_cnt), 2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom % 4) == 0;
            cfg_div   = DIV_W'($urandom_range(0, 9));
            start     = ($urandom % 5) == 0;
            stop      = ($urandom % 9) == 0;
            step();
            if ($urandom % 400 == 0) async_rst();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/tick_sched.md
TICK_SCHED -- requirements
Module: tick_sched

Interface
REQ-001 SHALL have parameter DIV_W, default 27, meaning the width of the divisor and prescale counter.
REQ-002 SHALL have parameter DEF_DIV, default 25000000, meaning the divisor loaded at reset.
REQ-003 SHALL have parameter SEC_W, default 16, meaning the width of the tick event counter.
REQ-004 SHALL have port clki, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port cfg_valid, input, 1 bit: a new divisor is offered.
REQ-007 SHALL have port cfg_div, input, DIV_W bits: the offered divisor.
REQ-008 SHALL have port cfg_ready, output, 1 bit: the divisor can be accepted this cycle.
REQ-009 SHALL have port start, input, 1 bit: run/resume request (level sampled each cycle).
REQ-010 SHALL have port stop, input, 1 bit: pause/halt request (level sampled each cycle).
REQ-011 SHALL have port tick, output, 1 bit: one-cycle pulse per elapsed divisor period.
REQ-012 SHALL have port clk_out, output, 1 bit: square wave toggling on every tick.
REQ-013 SHALL have port sec_cnt, output, SEC_W bits: count of ticks since leaving IDLE.
REQ-014 SHALL have port state, output, 2 bits: 00 IDLE, 01 RUN, 10 PAUSE.

Function
REQ-015 SHALL hold an internal divisor register div_r; the FSM states are IDLE, RUN and PAUSE.
REQ-016 SHALL drive cfg_ready = 1 only in IDLE, combinationally from state.
REQ-017 SHALL accept cfg_div into div_r on an edge where cfg_valid && cfg_ready; values below 2 SHALL be stored as 2.
REQ-018 SHALL leave div_r unchanged when cfg_valid is asserted outside IDLE; no error and no queuing.
REQ-019 In IDLE, start && !stop SHALL move to RUN with cnt=0 and sec_cnt=0.
REQ-020 If cfg is accepted on the same edge as the start of REQ-019, the new divisor SHALL govern the first period.
REQ-021 In RUN, cnt SHALL increment by 1 per cycle; at cnt==div_r-1 it SHALL wrap to 0 on the same edge that registers tick=1, toggles clk_out and increments sec_cnt.
REQ-022 The first tick SHALL therefore be high in the cycle following the div_r-th edge after the start edge; later ticks SHALL follow every div_r cycles.
REQ-023 tick SHALL be high for exactly 1 cycle per period and low in IDLE and PAUSE.
REQ-024 sec_cnt SHALL wrap from all-ones to 0 without saturating.
REQ-025 In RUN, stop SHALL move to PAUSE, freezing cnt, sec_cnt and clk_out.
REQ-026 stop SHALL win over start when both are asserted in the same cycle.
REQ-027 A tick due on the stop edge SHALL still be registered.
REQ-028 In PAUSE, start && !stop SHALL return to RUN, continuing from the frozen cnt value.
REQ-029 In PAUSE, stop SHALL return to IDLE, clearing cnt, sec_cnt and clk_out.
REQ-030 Unused state encoding 11 SHALL recover to IDLE on the next edge.
REQ-031 All outputs except cfg_ready SHALL be registered.

Reset
REQ-032 While rst_n=0, the block SHALL immediately force state=IDLE, div_r=DEF_DIV, cnt=0, sec_cnt=0, tick=0 and clk_out=0, independent of clki.
REQ-033 Reset asserted mid-RUN or mid-PAUSE SHALL abandon the period in progress; no tick SHALL be emitted.
REQ-034 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled.

Verification
REQ-035 Load and run: reset, cfg_div=4 with cfg_valid, start on the same edge -> ticks after edges 4, 8, 12; sec_cnt=1, 2, 3; clk_out toggles at each tick.
REQ-036 Clamp: cfg_div=0 loaded, then start -> a tick every 2 cycles; clk_out period = 4 cycles.
REQ-037 Pause and resume: div=5, stop for 1 cycle after 3 cycles of RUN, resume 10 cycles later -> next tick exactly 2 RUN cycles after resume; sec_cnt unchanged during PAUSE.
REQ-038 Config blocked: cfg_valid with cfg_div=7 during RUN -> cfg_ready=0 and the tick spacing stays at the old divisor.
REQ-039 Priority and wrap: start && stop together in RUN -> PAUSE; with SEC_W=4, run 17 ticks -> sec_cnt reads 1.
REQ-040 Async reset: rst_n pulsed low between clock edges mid-RUN -> outputs clear before the next edge; state=00; div_r=DEF_DIV.
